// File: rtl/adc_link_pkg.sv
// Shared constants and types for the ADC link. The receive side imports the
// same package, so the framing and field offsets cannot drift apart.
package adc_link_pkg;

  localparam int unsigned CH_W      = 14;
  localparam int unsigned FRAME_W   = 7;
  localparam int unsigned WORD_W    = 35;
  localparam int unsigned CHA_LSB   = 0;
  localparam int unsigned CHB_LSB   = 14;
  localparam int unsigned FRAME_LSB = 28;

  localparam logic [FRAME_W-1:0] FRAME_PATTERN = 7'b1110000;
  localparam logic [CH_W-1:0]    TRAIN_WORD    = 14'h2A5C;
  localparam logic [CH_W-1:0]    CHK_A         = 14'h2AAA;
  localparam logic [CH_W-1:0]    CHK_B         = 14'h1555;
  localparam logic [CH_W-1:0]    RAMP_B_OFFSET = 14'h2000;

  typedef enum logic [1:0] {
    MODE_STREAM  = 2'd0,
    MODE_RAMP    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_ZERO    = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  function automatic logic [WORD_W-1:0] pack_word(input logic [CH_W-1:0] chb,
                                                  input logic [CH_W-1:0] cha);
    logic [WORD_W-1:0] w;
    w = '0;
    w[FRAME_LSB +: FRAME_W] = FRAME_PATTERN;
    w[CHB_LSB +: CH_W]      = chb;
    w[CHA_LSB +: CH_W]      = cha;
    return w;
  endfunction

endpackage

// File: rtl/adc_link_tx_if.sv
// Sample stream handshake into the link transmitter.
interface adc_link_tx_if;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/adc_link_patgen.sv
// Ramp and checkerboard test-pattern generator. Each pattern only advances
// while selected, so switching modes resumes where the pattern left off.
module adc_link_patgen
  import adc_link_pkg::*;
(
  input  logic            clk_adc,
  input  logic            reset,
  input  logic            clear,
  input  logic            advance,
  input  mode_t           mode,
  output logic [CH_W-1:0] cha,
  output logic [CH_W-1:0] chb
);

  logic [CH_W-1:0] ramp;
  logic            phase;

  always_ff @(posedge clk_adc) begin
    if (reset || clear) begin
      ramp  <= '0;
      phase <= 1'b0;
    end else if (advance) begin
      if (mode == MODE_RAMP)    ramp  <= ramp + CH_W'(1);
      if (mode == MODE_CHECKER) phase <= ~phase;
    end
  end

  always_comb begin
    cha = '0;
    chb = '0;
    case (mode)
      MODE_RAMP: begin
        cha = ramp;
        chb = ramp + RAMP_B_OFFSET;
      end
      MODE_CHECKER: begin
        cha = phase ? CHK_B : CHK_A;
        chb = ~cha;
      end
      default: begin
        cha = '0;
        chb = '0;
      end
    endcase
  end

endmodule

// File: rtl/adc_link_tx.sv
// ADC link transmitter: IDLE/TRAIN/RUN sequencing, payload selection and the
// registered word to the serializer.
module adc_link_tx
  import adc_link_pkg::*;
#(
  parameter int unsigned TRAIN_LEN  = 64,
  parameter int unsigned UNDERRUN_W = 16
) (
  input  logic                  clk_adc,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  train_req,
  input  logic [1:0]            mode,
  adc_link_tx_if.slave          stream,
  output logic [WORD_W-1:0]     word_out,
  output logic                  training,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);

  localparam int unsigned     TC_W       = $clog2(TRAIN_LEN + 1);
  localparam logic [TC_W-1:0] TRAIN_LAST = TC_W'(TRAIN_LEN - 1);

  state_t          state;
  logic [TC_W-1:0] train_cnt;
  mode_t           mode_q;
  logic [CH_W-1:0] last_cha, last_chb;
  logic [CH_W-1:0] s_cha, s_chb;
  logic [CH_W-1:0] pg_cha, pg_chb;
  logic [CH_W-1:0] cha_sel, chb_sel;
  logic            stream_take;
  logic            underrun;
  logic            unused_sdata_bits;

  assign mode_q            = mode_t'(mode);
  assign s_cha             = stream.s_data[13:0];
  assign s_chb             = stream.s_data[29:16];
  assign unused_sdata_bits = ^{stream.s_data[31:30], stream.s_data[15:14]};
  assign stream.s_ready    = (state == ST_RUN) && (mode_q == MODE_STREAM);

  // Holding the generator in clear outside RUN makes every RUN entry start at zero.
  adc_link_patgen u_patgen (
    .clk_adc (clk_adc),
    .reset   (reset),
    .clear   (state != ST_RUN),
    .advance (state == ST_RUN),
    .mode    (mode_q),
    .cha     (pg_cha),
    .chb     (pg_chb)
  );

  always_comb begin
    cha_sel     = '0;
    chb_sel     = '0;
    stream_take = 1'b0;
    underrun    = 1'b0;
    case (state)
      ST_TRAIN: begin
        cha_sel = TRAIN_WORD;
        chb_sel = TRAIN_WORD;
      end
      ST_RUN: begin
        case (mode_q)
          MODE_STREAM: begin
            if (stream.s_valid) begin
              stream_take = 1'b1;
              cha_sel     = s_cha;
              chb_sel     = s_chb;
            end else begin
              underrun = 1'b1;
              cha_sel  = last_cha;
              chb_sel  = last_chb;
            end
          end
          MODE_RAMP, MODE_CHECKER: begin
            cha_sel = pg_cha;
            chb_sel = pg_chb;
          end
          default: begin
            cha_sel = '0;
            chb_sel = '0;
          end
        endcase
      end
      default: begin
        cha_sel = '0;
        chb_sel = '0;
      end
    endcase
  end

  always_ff @(posedge clk_adc) begin
    if (reset) begin
      state        <= ST_IDLE;
      train_cnt    <= '0;
      training     <= 1'b0;
      word_out     <= '0;
      underrun_cnt <= '0;
      last_cha     <= '0;
      last_chb     <= '0;
    end else begin
      word_out <= pack_word(chb_sel, cha_sel);
      if (stream_take) begin
        last_cha <= s_cha;
        last_chb <= s_chb;
      end
      if (underrun && (underrun_cnt != '1))
        underrun_cnt <= underrun_cnt + UNDERRUN_W'(1);

      // Dropping enable wins over any training request in the same cycle.
      if (!enable) begin
        state     <= ST_IDLE;
        training  <= 1'b0;
        train_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state     <= ST_TRAIN;
            training  <= 1'b1;
            train_cnt <= '0;
          end
          ST_TRAIN: begin
            if (train_req) begin
              train_cnt <= '0;
            end else if (train_cnt == TRAIN_LAST) begin
              state    <= ST_RUN;
              training <= 1'b0;
            end else begin
              train_cnt <= train_cnt + TC_W'(1);
            end
          end
          ST_RUN: begin
            if (train_req) begin
              state     <= ST_TRAIN;
              training  <= 1'b1;
              train_cnt <= '0;
            end
          end
          default: begin
            state    <= ST_IDLE;
            training <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_link_tx.sv
// Scoreboard bench for adc_link_tx: directed stimulus queues hand-computed
// expectations, an independent monitor compares them after each clock edge.
module tb_adc_link_tx;

  logic        clk_adc = 1'b0;
  logic        reset;
  logic        enable;
  logic        train_req;
  logic [1:0]  mode;
  logic [34:0] word_out;
  logic        training;
  logic [15:0] underrun_cnt;

  adc_link_tx_if stream();

  adc_link_tx #(.TRAIN_LEN(64), .UNDERRUN_W(16)) dut (
    .clk_adc      (clk_adc),
    .reset        (reset),
    .enable       (enable),
    .train_req    (train_req),
    .mode         (mode),
    .stream       (stream),
    .word_out     (word_out),
    .training     (training),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk_adc = ~clk_adc;

  typedef struct packed {
    logic [34:0] w;
    logic        tr;
    logic        ucc;
    logic [15:0] uc;
    logic        rc;
    logic        r;
  } exp_t;

  exp_t        q[$];
  exp_t        m;
  int unsigned checks   = 0;
  int unsigned errors   = 0;
  int unsigned mon_cyc  = 0;
  int unsigned idle_cnt = 0;
  logic        stim_done = 1'b0;

  function automatic logic [34:0] mk(input logic [13:0] b, input logic [13:0] a);
    return {7'b1110000, b, a};
  endfunction

  localparam logic [34:0] W_IDLE  = 35'h7_0000_0000;
  localparam logic [34:0] W_TRAIN = 35'h7_0A97_2A5C;

  // One clock edge; queue what the outputs must show after it.
  task automatic cyc(input logic [34:0] w, input logic tr, input logic ucc,
                     input logic [15:0] uc, input logic rc, input logic r);
    exp_t e;
    @(posedge clk_adc);
    #1;
    e.w = w; e.tr = tr; e.ucc = ucc; e.uc = uc; e.rc = rc; e.r = r;
    q.push_back(e);
    #2;
  endtask

  // Monitor: compares at posedge+2, before stimulus changes inputs at posedge+3.
  initial begin
    forever begin
      @(posedge clk_adc);
      #2;
      if (q.size() != 0) begin
        m = q.pop_front();
        mon_cyc++;
        checks++;
        if (word_out !== m.w) begin
          errors++;
          $display("FAIL word_out cyc=%0d actual=%h required=%h", mon_cyc, word_out, m.w);
        end
        checks++;
        if (training !== m.tr) begin
          errors++;
          $display("FAIL training cyc=%0d actual=%b required=%b", mon_cyc, training, m.tr);
        end
        if (m.ucc) begin
          checks++;
          if (underrun_cnt !== m.uc) begin
            errors++;
            $display("FAIL underrun_cnt cyc=%0d actual=%h required=%h", mon_cyc, underrun_cnt, m.uc);
          end
        end
        if (m.rc) begin
          checks++;
          if (stream.s_ready !== m.r) begin
            errors++;
            $display("FAIL s_ready cyc=%0d actual=%b required=%b", mon_cyc, stream.s_ready, m.r);
          end
        end
      end else if (stim_done) begin
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
      if (stim_done) begin
        idle_cnt++;
        if (idle_cnt > 4) begin
          errors++;
          $display("FAIL drain pending=%0d required=0", q.size());
          $display("Simulation finished: %0d checks, %0d errors", checks, errors);
          $finish;
        end
      end
    end
  end

  initial begin
    logic [13:0] a;
    reset = 1'b1; enable = 1'b0; train_req = 1'b0; mode = 2'd0;
    stream.s_valid = 1'b0; stream.s_data = '0;

    // Reset state
    cyc(35'h0, 1'b0, 1'b1, 16'h0, 1'b1, 1'b0);
    cyc(35'h0, 1'b0, 1'b1, 16'h0, 1'b1, 1'b0);
    reset = 1'b0;
    cyc(W_IDLE, 1'b0, 1'b1, 16'h0, 1'b1, 1'b0);

    // Training burst: training high for 64 edges, training word lags one cycle
    enable = 1'b1;
    cyc(W_IDLE, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 2; i <= 64; i++) cyc(W_TRAIN, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    stream.s_valid = 1'b1; stream.s_data = 32'h1234_0567;
    cyc(W_TRAIN, 1'b0, 1'b1, 16'h0, 1'b1, 1'b1);

    // Stream mode, including masked-off upper bits
    cyc(mk(14'h1234, 14'h0567), 1'b0, 1'b1, 16'h0, 1'b1, 1'b1);
    stream.s_data = 32'hC00A_4001;
    cyc(mk(14'h000A, 14'h0001), 1'b0, 1'b1, 16'h0, 1'b1, 1'b1);
    stream.s_data = 32'h3FFF_3FFF;
    cyc(mk(14'h3FFF, 14'h3FFF), 1'b0, 1'b1, 16'h0, 1'b1, 1'b1);

    // Underrun: repeat last sample, count up and saturate
    stream.s_valid = 1'b0; stream.s_data = 32'hDEAD_BEEF;
    for (int j = 1; j <= 65600; j++)
      cyc(mk(14'h3FFF, 14'h3FFF), 1'b0, 1'b1,
          (j > 65535) ? 16'hFFFF : 16'(j), 1'b1, 1'b1);

    // Ramp mode across the 14-bit wrap; stream data offered but not accepted
    mode = 2'd1; stream.s_valid = 1'b1; stream.s_data = 32'h0BAD_0BAD;
    for (int k = 0; k < 16400; k++) begin
      a = 14'(k);
      cyc(mk(a + 14'h2000, a), 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    end

    // Checker, then mode switches resume each pattern where it stopped
    mode = 2'd2;
    cyc(mk(14'h1555, 14'h2AAA), 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    cyc(mk(14'h2AAA, 14'h1555), 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    cyc(mk(14'h1555, 14'h2AAA), 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    mode = 2'd1;
    cyc(mk(14'h2010, 14'h0010), 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    mode = 2'd2;
    cyc(mk(14'h2AAA, 14'h1555), 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    mode = 2'd3;
    cyc(mk(14'h0000, 14'h0000), 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    mode = 2'd0; stream.s_valid = 1'b0;
    cyc(mk(14'h3FFF, 14'h3FFF), 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1);

    // Retrain from RUN
    train_req = 1'b1;
    cyc(mk(14'h3FFF, 14'h3FFF), 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    train_req = 1'b0;
    for (int i = 2; i <= 64; i++) cyc(W_TRAIN, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    mode = 2'd2;
    cyc(W_TRAIN, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    cyc(mk(14'h1555, 14'h2AAA), 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    mode = 2'd1;
    cyc(mk(14'h2000, 14'h0000), 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

    // enable low beats train_req in the same cycle
    train_req = 1'b1; enable = 1'b0;
    cyc(mk(14'h2001, 14'h0001), 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    train_req = 1'b0;
    cyc(W_IDLE, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

    // Reset mid-TRAIN
    enable = 1'b1;
    cyc(W_IDLE, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cyc(W_TRAIN, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    reset = 1'b1; enable = 1'b0;
    cyc(35'h0, 1'b0, 1'b1, 16'h0, 1'b1, 1'b0);
    reset = 1'b0;
    cyc(W_IDLE, 1'b0, 1'b1, 16'h0, 1'b1, 1'b0);
    cyc(W_IDLE, 1'b0, 1'b1, 16'h0, 1'b1, 1'b0);

    stim_done = 1'b1;
  end

endmodule
